viterbi_ctrl_seq: RTL

- Parametrised successor to the fixed-length Viterbi stage controller.
- Sequences the extract, branch, add, memory and traceback enables for frames whose length is programmable at run time, with a configurable traceback depth.
- Adds start queuing, continuous back-to-back frames, abort, a done pulse and overrun detection.
- Sits between the host/symbol source and the Viterbi datapath stages.

---
 rtl/viterbi_ctrl_seq.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/viterbi_ctrl_seq.sv
// Stage-enable sequencer for the Viterbi datapath: programmable frame length,
// fixed traceback depth, start queuing, continuous mode, abort and overrun flag.
module viterbi_ctrl_seq #(
    parameter int FRAME_LEN = 12,
    parameter int TB_LEN    = 12,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic             abort,
    input  logic             cont_i,
    input  logic [CNT_W-1:0] frame_len_i,
    output logic             en_extract,
    output logic             en_branch,
    output logic             en_add,
    output logic             en_memory,
    output logic             en_traceback,
    output logic             busy,
    output logic             done,
    output logic             overrun,
    output logic [CNT_W-1:0] sym_cnt,
    output logic [CNT_W-1:0] frame_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        PRIME1,
        PRIME2,
        RUN,
        TB,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] LEN_MIN = CNT_W'(3);
    localparam logic [CNT_W-1:0] TB_LAST = CNT_W'(TB_LEN - 1);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] tb_cnt;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] len_clamped;
    logic             start_pend;
    logic             launch;

    // Enables listed as extract/branch/add/memory/traceback.
    function automatic logic [4:0] stage_en(input state_t s);
        case (s)
            PRIME1:  return 5'b10000;
            PRIME2:  return 5'b11100;
            RUN:     return 5'b11110;
            TB:      return 5'b00011;
            default: return 5'b00000;
        endcase
    endfunction

    // NOTE: every variable in a combinational block gets a default first so no latch is inferred.
    always_comb begin
        len_clamped = frame_len_i;
        if (frame_len_i < LEN_MIN)
            len_clamped = LEN_MIN;
        else if (frame_len_i > LEN_MAX)
            len_clamped = LEN_MAX;
    end

    assign launch = en && (start || start_pend) &&
                    (state == IDLE || (state == DONE && cont_i));

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else if (en) begin
            case (state)
                IDLE:    if (launch) state_nxt = PRIME1;
                PRIME1:  state_nxt = PRIME2;
                PRIME2:  state_nxt = RUN;
                RUN:     if (sym_cnt == len_q - ONE) state_nxt = TB;
                TB:      if (tb_cnt == TB_LAST) state_nxt = DONE;
                DONE:    state_nxt = launch ? PRIME1 : IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; outputs are
    // registered from state_nxt so they line up cycle-for-cycle with state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            en_extract   <= 1'b0;
            en_branch    <= 1'b0;
            en_add       <= 1'b0;
            en_memory    <= 1'b0;
            en_traceback <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            overrun      <= 1'b0;
            sym_cnt      <= '0;
            tb_cnt       <= '0;
            frame_cnt    <= '0;
            start_pend   <= 1'b0;
            len_q        <= LEN_MAX;
        end else begin
            state <= state_nxt;
            {en_extract, en_branch, en_add, en_memory, en_traceback} <= stage_en(state_nxt);
            busy  <= !(state_nxt inside {IDLE, DONE});
            done  <= (state_nxt == DONE);

            if (abort) begin
                sym_cnt    <= '0;
                tb_cnt     <= '0;
                start_pend <= 1'b0;
                overrun    <= 1'b0;
            end else begin
                if (launch) begin
                    sym_cnt    <= '0;
                    start_pend <= 1'b0;
                    len_q      <= len_clamped;
                end else begin
                    // A start that cannot launch is queued; a second one is lost.
                    if (start) begin
                        if (start_pend)
                            overrun <= 1'b1;
                        start_pend <= 1'b1;
                    end
                    if (en) begin
                        case (state)
                            PRIME1, PRIME2, RUN: sym_cnt <= sym_cnt + ONE;
                            TB:                  tb_cnt  <= tb_cnt + ONE;
                            default:             ;
                        endcase
                    end
                end
                if (en && state == RUN && state_nxt == TB)
                    tb_cnt <= '0;
                if (en && state == DONE)
                    frame_cnt <= frame_cnt + ONE;
            end
        end
    end

endmodule
